autosa_unit_done_intr: RTL and testbench



---
 rtl/autosa_glb_pkg.sv | 25 ++
 rtl/autosa_outs_cnt.sv | 50 +++++
 rtl/autosa_unit_done_intr.sv | 133 +++++++++++++
 tb/tb_autosa_unit_done_intr.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/autosa_glb_pkg.sv
// Shared definitions for the per-unit done-interrupt trackers:
// tracker state encoding, ping-pong group index type and a helper
// that turns a group index into its one-hot done/clear bit.
package autosa_glb_pkg;

   localparam int AUTOSA_NUM_GRP = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } autosa_state_e;

   typedef logic autosa_grp_t;

   // One-hot bit for a register group, used for the done pulse and the op_en clear.
   function automatic logic [AUTOSA_NUM_GRP-1:0] grp_onehot(input autosa_grp_t grp);
      logic [AUTOSA_NUM_GRP-1:0] vec;
      vec      = '0;
      vec[grp] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/autosa_outs_cnt.sv
// Up/down saturating counter of outstanding memory writes.
// Only instantiated when AUTOSA_DONE_INTR_WAIT_RSP_EN is defined.
// cnt_nxt exposes the value the counter takes at the next edge so the
// tracker can leave DRAIN in the same cycle as the final response.
// underflow/overflow are single-cycle flags for an illegal response or a
// request arriving while the counter is already full.
module autosa_outs_cnt #(
   parameter int OUTS_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              dec,
   output logic [OUTS_W-1:0] cnt,
   output logic [OUTS_W-1:0] cnt_nxt,
   output logic              underflow,
   output logic              overflow
);

   // Next count: a request and a response in the same cycle cancel out;
   // a response at zero or a request at full leaves the count where it is.
   always_comb begin
      cnt_nxt   = cnt;
      underflow = 1'b0;
      overflow  = 1'b0;
      if (inc && !dec) begin
         if (cnt == '1) begin
            overflow = 1'b1;
         end else begin
            cnt_nxt = cnt + OUTS_W'(1);
         end
      end else if (dec && !inc) begin
         if (cnt == '0) begin
            underflow = 1'b1;
         end else begin
            cnt_nxt = cnt - OUTS_W'(1);
         end
      end
   end

   // Counter register, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/autosa_unit_done_intr.sv
// Per-unit completion tracker producing the 2-bit done interrupt pulse for
// the global interrupt controller. It follows the unit's ping-pong register
// groups: start on the active group's op_en, count output beats up to the
// latched length, optionally drain outstanding writes, then pulse done and
// op_en_clr for that group and move the pointer to the other group.
// Build option: AUTOSA_DONE_INTR_WAIT_RSP_EN makes DRAIN wait for every
// write response; without it DRAIN lasts exactly one cycle and the write
// request/response inputs are ignored.
module autosa_unit_done_intr
   import autosa_glb_pkg::*;
#(
   parameter int CNT_W  = 24,
   parameter int OUTS_W = 8
) (
   input  logic                      autosa_core_clk,
   input  logic                      autosa_core_rst,
   input  logic [AUTOSA_NUM_GRP-1:0] reg2dp_op_en,
   input  logic [CNT_W-1:0]          reg2dp_len0,
   input  logic [CNT_W-1:0]          reg2dp_len1,
   input  logic                      beat_vld,
   input  logic                      wr_req_acc,
   input  logic                      wr_rsp,
   output logic [AUTOSA_NUM_GRP-1:0] done_intr_pd,
   output logic [AUTOSA_NUM_GRP-1:0] op_en_clr,
   output logic                      cur_grp,
   output logic                      busy,
   output logic                      err
);

   autosa_state_e    state;
   autosa_grp_t      grp_q;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] sel_len;
   logic             outs_zero_nxt;
   logic             outs_err;

`ifdef AUTOSA_DONE_INTR_WAIT_RSP_EN
   logic [OUTS_W-1:0] outs_cnt;
   logic [OUTS_W-1:0] outs_cnt_nxt;
   logic              outs_underflow;
   logic              outs_overflow;

   autosa_outs_cnt #(
      .OUTS_W (OUTS_W)
   ) u_outs_cnt (
      .clk       (autosa_core_clk),
      .rst       (autosa_core_rst),
      .inc       (wr_req_acc),
      .dec       (wr_rsp),
      .cnt       (outs_cnt),
      .cnt_nxt   (outs_cnt_nxt),
      .underflow (outs_underflow),
      .overflow  (outs_overflow)
   );

   // Drain completes on the cycle whose post-edge outstanding count is zero.
   always_comb begin
      outs_zero_nxt = (outs_cnt_nxt == '0);
      outs_err      = outs_underflow | outs_overflow;
   end
`else
   logic [OUTS_W-1:0] unused_outs;
   logic              unused_wr;

   assign unused_outs = '0;
   assign unused_wr   = wr_req_acc ^ wr_rsp;

   // Without response tracking DRAIN is a fixed one-cycle stage.
   always_comb begin
      outs_zero_nxt = 1'b1;
      outs_err      = 1'b0;
   end
`endif

   // Length of the group the pointer currently selects, latched on start.
   always_comb begin
      sel_len = grp_q ? reg2dp_len1 : reg2dp_len0;
   end

   // Tracker FSM plus pointer, beat counter and sticky error.
   always_ff @(posedge autosa_core_clk) begin
      if (autosa_core_rst) begin
         state    <= IDLE;
         grp_q    <= 1'b0;
         len_q    <= '0;
         beat_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if ((beat_vld && (state != RUN)) || outs_err) begin
            err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (reg2dp_op_en[grp_q]) begin
                  len_q    <= sel_len;
                  beat_cnt <= '0;
                  state    <= (sel_len != '0) ? RUN : DRAIN;
               end
            end
            RUN: begin
               if (beat_vld) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
                  if ((beat_cnt + CNT_W'(1)) == len_q) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (outs_zero_nxt) begin
                  state <= DONE;
               end
            end
            DONE: begin
               grp_q <= ~grp_q;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Outputs decoded purely from registered state: no input reaches an output.
   always_comb begin
      done_intr_pd = (state == DONE) ? grp_onehot(grp_q) : '0;
      op_en_clr    = (state == DONE) ? grp_onehot(grp_q) : '0;
      cur_grp      = grp_q;
      busy         = (state != IDLE);
   end

endmodule

// File: tb/tb_autosa_unit_done_intr.sv
// Self-checking bench for autosa_unit_done_intr. The reference model works at
// the level of whole operations: for each op it knows the group, the length
// and when the last beat was driven, and expects the done/clear pulse exactly
// two cycles after that beat (two cycles after start for zero length), with
// the group pointer flipping one cycle later.
`timescale 1ns/1ps
module tb_autosa_unit_done_intr;

   localparam int CNT_W  = 24;
   localparam int OUTS_W = 8;

   logic             clk;
   logic             rst;
   logic [1:0]       op_en;
   logic [CNT_W-1:0] len0;
   logic [CNT_W-1:0] len1;
   logic             beat_vld;
   logic             wr_req_acc;
   logic             wr_rsp;
   logic [1:0]       done_intr_pd;
   logic [1:0]       op_en_clr;
   logic             cur_grp;
   logic             busy;
   logic             err;

   int   checks;
   int   failures;
   logic model_grp;

   autosa_unit_done_intr #(
      .CNT_W  (CNT_W),
      .OUTS_W (OUTS_W)
   ) dut (
      .autosa_core_clk (clk),
      .autosa_core_rst (rst),
      .reg2dp_op_en    (op_en),
      .reg2dp_len0     (len0),
      .reg2dp_len1     (len1),
      .beat_vld        (beat_vld),
      .wr_req_acc      (wr_req_acc),
      .wr_rsp          (wr_rsp),
      .done_intr_pd    (done_intr_pd),
      .op_en_clr       (op_en_clr),
      .cur_grp         (cur_grp),
      .busy            (busy),
      .err             (err)
   );

   // 10 ns core clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] onehot(input logic g);
      return g ? 2'b10 : 2'b01;
   endfunction

   task automatic setLen(input logic g, input logic [CNT_W-1:0] v);
      if (g) len1 = v;
      else   len0 = v;
   endtask

   // One complete operation on group g with length len and random beat gaps.
   task automatic runOp(input logic g, input int len, input int max_gap);
      int gaps;
      checkOutput("cur_grp_pre", {31'b0, cur_grp}, {31'b0, g});
      setLen(g, CNT_W'(len));
      op_en[g] = 1'b1;
      applyStimulus();
      checkOutput("busy_start", {31'b0, busy}, 32'd1);
      setLen(g, CNT_W'($urandom_range(1, 255)));
      for (int b = 0; b < len; b++) begin
         gaps = $urandom_range(0, max_gap);
         for (int k = 0; k < gaps; k++) begin
            checkOutput("done_early_gap", {30'b0, done_intr_pd}, 32'd0);
            applyStimulus();
         end
         beat_vld = 1'b1;
         checkOutput("done_early_beat", {30'b0, done_intr_pd}, 32'd0);
         applyStimulus();
         beat_vld = 1'b0;
      end
      checkOutput("done_n1", {30'b0, done_intr_pd}, 32'd0);
      checkOutput("busy_n1", {31'b0, busy}, 32'd1);
      applyStimulus();
      checkOutput("done_pulse", {30'b0, done_intr_pd}, {30'b0, onehot(g)});
      checkOutput("clr_pulse", {30'b0, op_en_clr}, {30'b0, onehot(g)});
      op_en[g] = 1'b0;
      applyStimulus();
      checkOutput("done_after", {30'b0, done_intr_pd}, 32'd0);
      checkOutput("clr_after", {30'b0, op_en_clr}, 32'd0);
      checkOutput("busy_after", {31'b0, busy}, 32'd0);
      model_grp = ~g;
      checkOutput("cur_grp_flip", {31'b0, cur_grp}, {31'b0, model_grp});
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      model_grp = 1'b0;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      model_grp  = 1'b0;
      rst        = 1'b1;
      op_en      = 2'b00;
      len0       = '0;
      len1       = '0;
      beat_vld   = 1'b0;
      wr_req_acc = 1'b0;
      wr_rsp     = 1'b0;
      applyStimulus();
      applyStimulus();
      rst = 1'b0;

      // Reset values.
      checkOutput("rst_done", {30'b0, done_intr_pd}, 32'd0);
      checkOutput("rst_clr", {30'b0, op_en_clr}, 32'd0);
      checkOutput("rst_grp", {31'b0, cur_grp}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_err", {31'b0, err}, 32'd0);

      // Group 0 single op, four back-to-back beats.
      runOp(1'b0, 4, 0);

      // Zero-length op on group 1 brings the pointer back to 0.
      runOp(1'b1, 0, 0);

      // Ping-pong with both enables raised together.
      op_en = 2'b11;
      runOp(1'b0, 3, 1);
      runOp(1'b1, 2, 1);
      checkOutput("pp_op_en", {30'b0, op_en}, 32'd0);

      // Zero length on group 0.
      runOp(1'b0, 0, 0);

      // Randomized operations on whichever group the pointer selects.
      for (int i = 0; i < 8; i++) begin
         runOp(model_grp, $urandom_range(0, 7), $urandom_range(0, 2));
      end

      // Stray beat in IDLE sets the sticky error without starting anything.
      checkOutput("err_pre", {31'b0, err}, 32'd0);
      beat_vld = 1'b1;
      applyStimulus();
      beat_vld = 1'b0;
      checkOutput("err_set", {31'b0, err}, 32'd1);
      checkOutput("err_busy", {31'b0, busy}, 32'd0);
      checkOutput("err_done", {30'b0, done_intr_pd}, 32'd0);
      applyStimulus();
      checkOutput("err_done2", {30'b0, done_intr_pd}, 32'd0);
      runOp(model_grp, 3, 1);
      checkOutput("err_sticky", {31'b0, err}, 32'd1);

`ifdef AUTOSA_DONE_INTR_WAIT_RSP_EN
      // Response with nothing outstanding.
      doReset();
      checkOutput("uf_pre", {31'b0, err}, 32'd0);
      wr_rsp = 1'b1;
      applyStimulus();
      wr_rsp = 1'b0;
      checkOutput("uf_err", {31'b0, err}, 32'd1);
      checkOutput("uf_done", {30'b0, done_intr_pd}, 32'd0);

      // Drain: three writes outstanding after the last beat.
      doReset();
      len0 = CNT_W'(2);
      op_en[0] = 1'b1;
      applyStimulus();
      wr_req_acc = 1'b1;
      beat_vld   = 1'b1;
      applyStimulus();
      applyStimulus();
      beat_vld = 1'b0;
      applyStimulus();
      wr_req_acc = 1'b1;
      wr_rsp     = 1'b1;
      applyStimulus();
      wr_req_acc = 1'b0;
      wr_rsp     = 1'b0;
      for (int k = 0; k < 10; k++) begin
         checkOutput("drain_wait_done", {30'b0, done_intr_pd}, 32'd0);
         checkOutput("drain_wait_busy", {31'b0, busy}, 32'd1);
         applyStimulus();
      end
      for (int r = 0; r < 3; r++) begin
         wr_rsp = 1'b1;
         checkOutput("drain_rsp_done", {30'b0, done_intr_pd}, 32'd0);
         applyStimulus();
         wr_rsp = 1'b0;
      end
      checkOutput("drain_done", {30'b0, done_intr_pd}, 32'd1);
      checkOutput("drain_clr", {30'b0, op_en_clr}, 32'd1);
      op_en[0] = 1'b0;
      applyStimulus();
      checkOutput("drain_idle", {31'b0, busy}, 32'd0);
      checkOutput("drain_err", {31'b0, err}, 32'd0);
      model_grp = 1'b1;
      runOp(model_grp, 2, 1);
`endif

      // Reset in the middle of a five-beat op after two beats.
      setLen(model_grp, CNT_W'(5));
      op_en[model_grp] = 1'b1;
      applyStimulus();
      beat_vld = 1'b1;
      applyStimulus();
      applyStimulus();
      beat_vld = 1'b0;
      checkOutput("mid_busy", {31'b0, busy}, 32'd1);
      rst   = 1'b1;
      op_en = 2'b00;
      applyStimulus();
      rst = 1'b0;
      model_grp = 1'b0;
      checkOutput("mid_done", {30'b0, done_intr_pd}, 32'd0);
      checkOutput("mid_clr", {30'b0, op_en_clr}, 32'd0);
      checkOutput("mid_grp", {31'b0, cur_grp}, 32'd0);
      checkOutput("mid_busy_rst", {31'b0, busy}, 32'd0);
      checkOutput("mid_err", {31'b0, err}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus();
         checkOutput("mid_no_done", {30'b0, done_intr_pd}, 32'd0);
      end
      runOp(model_grp, 2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
